// File: rtl/uart_tx.sv
// UART transmitter: TX byte FIFO plus 8N1/8N2 serialiser.
// Define UART_TX_PARITY_EN to build in the optional parity bit.
module uart_tx #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_fifo_wr,
    input  logic [7:0]    tx_fifo_data_in,
    input  logic [14:0]   uart_control,
    output logic          txd,
    output logic          tx_busy,
    output logic          tx_done,
    output logic          tx_fifo_full,
    output logic          tx_fifo_empty,
    output logic [AW:0]   tx_fifo_count,
    output logic          tx_overflow
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          tx_en;
    logic          start_ok;
    logic          bit_end;
    logic          last_stop;
    logic          frame_end;

    logic [2:0]    state;
    logic [9:0]    cnt;
    logic [9:0]    baud_lat;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          two_lat;
    logic          stop_idx;
    logic          unused_ctl;

`ifdef UART_TX_PARITY_EN
    logic          par_en_lat;
    logic          par_bit;
    assign unused_ctl = uart_control[1];
`else
    assign unused_ctl = ^{uart_control[4:3], uart_control[1]};
`endif

    assign tx_en     = uart_control[0];
    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign head      = mem[rd_ptr];
    assign bit_end   = (cnt == '0);
    assign last_stop = !two_lat || stop_idx;
    assign frame_end = (state == S_STOP) && bit_end && last_stop;
    assign start_ok  = tx_en && !empty;
    assign pop       = start_ok && ((state == S_IDLE) || frame_end);
    assign push      = tx_fifo_wr && (!full || pop);

    assign tx_fifo_full  = full;
    assign tx_fifo_empty = empty;
    assign tx_fifo_count = count;

    // FIFO storage: written on every accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_fifo_data_in;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (tx_fifo_wr && full && !pop) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // Frame FSM: start, 8 data bits LSB first, optional parity, stop bit(s)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            cnt      <= '0;
            baud_lat <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            two_lat  <= 1'b0;
            stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_lat <= 1'b0;
            par_bit    <= 1'b0;
`endif
        end else begin
            tx_done <= frame_end;
            if (pop) begin
                shreg    <= head;
                baud_lat <= uart_control[14:5];
                cnt      <= uart_control[14:5];
                two_lat  <= uart_control[2];
`ifdef UART_TX_PARITY_EN
                par_en_lat <= uart_control[3];
                par_bit    <= (^head) ^ uart_control[4];
`endif
                txd      <= 1'b0;
                tx_busy  <= 1'b1;
                state    <= S_START;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        txd <= 1'b1;
                    end
                    S_START: begin
                        if (bit_end) begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= '0;
                            cnt     <= baud_lat;
                            state   <= S_DATA;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            cnt <= baud_lat;
                            if (bit_idx == 3'd7) begin
                                txd      <= 1'b1;
                                stop_idx <= 1'b0;
                                state    <= S_STOP;
`ifdef UART_TX_PARITY_EN
                                if (par_en_lat) begin
                                    txd   <= par_bit;
                                    state <= S_PARITY;
                                end
`endif
                            end else begin
                                txd     <= shreg[0];
                                shreg   <= shreg >> 1;
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        if (bit_end) begin
                            txd      <= 1'b1;
                            stop_idx <= 1'b0;
                            cnt      <= baud_lat;
                            state    <= S_STOP;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (bit_end) begin
                            if (last_stop) begin
                                tx_busy <= 1'b0;
                                state   <= S_IDLE;
                            end else begin
                                stop_idx <= 1'b1;
                                cnt      <= baud_lat;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        txd     <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table, scoreboard of
// expected frames, serial-line monitor and hand-written corner cases.
module tb_uart_tx;

    localparam int DEPTH = 16;
    localparam int AW = $clog2(DEPTH);

    typedef struct {
        logic [7:0] data;
        logic [9:0] baud;
        bit         two;
        bit         pe;
        bit         po;
    } frame_t;

    typedef struct {
        frame_t f;
        int     exp_len;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_fifo_wr = 1'b0;
    logic [7:0]    tx_fifo_data_in = '0;
    logic [14:0]   uart_control = '0;
    logic          txd;
    logic          tx_busy;
    logic          tx_done;
    logic          tx_fifo_full;
    logic          tx_fifo_empty;
    logic [AW:0]   tx_fifo_count;
    logic          tx_overflow;

    int     n_vec = 0;
    int     n_err = 0;
    bit     mon_en = 1'b1;
    bit     mon_busy = 1'b0;
    frame_t sb[$];

    uart_tx #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tx_fifo_wr      (tx_fifo_wr),
        .tx_fifo_data_in (tx_fifo_data_in),
        .uart_control    (uart_control),
        .txd             (txd),
        .tx_busy         (tx_busy),
        .tx_done         (tx_done),
        .tx_fifo_full    (tx_fifo_full),
        .tx_fifo_empty   (tx_fifo_empty),
        .tx_fifo_count   (tx_fifo_count),
        .tx_overflow     (tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] mk_ctrl(input bit en, input frame_t f);
        return {f.baud, f.po, f.pe, f.two, 1'b0, en};
    endfunction

    // Reference frame: start, data LSB first, optional parity, stops
    function automatic void model(input frame_t f, output logic [11:0] b,
                                  output int n);
        b = '1;
        b[0] = 1'b0;
        b[8:1] = f.data;
        n = 10;
`ifdef UART_TX_PARITY_EN
        if (f.pe) begin
            b[9] = (^f.data) ^ f.po;
            n = 11;
        end
`endif
        if (f.two) n = n + 1;
    endfunction

    task automatic push(input logic [7:0] d);
        tx_fifo_wr = 1'b1;
        tx_fifo_data_in = d;
        @(negedge clk);
        tx_fifo_wr = 1'b0;
    endtask

    task automatic busy_run(input bit pre, output int len);
        len = 0;
        if (pre) @(negedge clk);
        while (tx_busy === 1'b1 && len < 5000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int max);
        int i;
        i = 0;
        while ((sb.size() != 0 || mon_busy || tx_busy !== 1'b0) && i < max) begin
            @(negedge clk);
            i++;
        end
        check("idle_timeout", 32'(i < max), 32'd1);
    endtask

    // Line monitor: decodes each frame against the head of the scoreboard
    initial begin
        frame_t      f;
        logic [11:0] eb;
        logic [11:0] ob;
        int          nb;
        bit          stable;
        bit          have_start;
        have_start = 1'b0;
        forever begin
            if (!have_start) @(negedge clk);
            have_start = 1'b0;
            if (!mon_en || txd !== 1'b0) continue;
            mon_busy = 1'b1;
            if (sb.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
                for (int i = 0; i < 20000 && txd !== 1'b1; i++) @(negedge clk);
                mon_busy = 1'b0;
                continue;
            end
            f = sb.pop_front();
            model(f, eb, nb);
            ob = '1;
            stable = 1'b1;
            for (int k = 0; k < nb; k++) begin
                for (int j = 0; j <= int'(f.baud); j++) begin
                    if (k != 0 || j != 0) begin
                        @(negedge clk);
                        if (tx_done !== 1'b0) stable = 1'b0;
                    end
                    if (j == 0) ob[k] = txd;
                    else if (txd !== ob[k]) stable = 1'b0;
                    if (tx_busy !== 1'b1) stable = 1'b0;
                end
            end
            @(negedge clk);
            check("frame_bits", 32'(ob), 32'(eb));
            check("frame_timing", 32'(stable), 32'd1);
            check("done_pulse", 32'(tx_done), 32'd1);
            if (txd === 1'b0 && tx_busy === 1'b1) have_start = 1'b1;
            else mon_busy = 1'b0;
        end
    end

    initial begin
        vec_t   vecs[6];
        frame_t fr;
        int     len;

        vecs[0] = '{'{8'hA5, 10'd3, 1'b0, 1'b0, 1'b0}, 40};
        vecs[1] = '{'{8'h00, 10'd0, 1'b1, 1'b0, 1'b0}, 11};
        vecs[2] = '{'{8'hFF, 10'd1, 1'b0, 1'b0, 1'b0}, 20};
        vecs[3] = '{'{8'h3C, 10'd2, 1'b1, 1'b0, 1'b0}, 33};
`ifdef UART_TX_PARITY_EN
        vecs[4] = '{'{8'hA5, 10'd1, 1'b0, 1'b1, 1'b0}, 22};
        vecs[5] = '{'{8'hA5, 10'd1, 1'b0, 1'b1, 1'b1}, 22};
`else
        vecs[4] = '{'{8'hA5, 10'd1, 1'b0, 1'b1, 1'b0}, 20};
        vecs[5] = '{'{8'h5A, 10'd1, 1'b1, 1'b1, 1'b1}, 22};
`endif

        // reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_count", 32'(tx_fifo_count), 32'd0);
        check("rst_empty", 32'(tx_fifo_empty), 32'd1);
        check("rst_full", 32'(tx_fifo_full), 32'd0);
        check("rst_ovf", 32'(tx_overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single frames from the vector table
        for (int v = 0; v < 6; v++) begin
            uart_control = mk_ctrl(1'b1, vecs[v].f);
            sb.push_back(vecs[v].f);
            push(vecs[v].f.data);
            check("lat_txd_high", 32'(txd), 32'd1);
            check("lat_count", 32'(tx_fifo_count), 32'd1);
            busy_run(1'b1, len);
            check("busy_len", 32'(len), 32'(vecs[v].exp_len));
            wait_idle(400);
            check("end_empty", 32'(tx_fifo_empty), 32'd1);
        end

        // fill past full with transmit disabled, then drain back-to-back
        fr = '{8'h00, 10'd0, 1'b0, 1'b0, 1'b0};
        uart_control = mk_ctrl(1'b0, fr);
        for (int i = 0; i < 17; i++) begin
            tx_fifo_wr = 1'b1;
            tx_fifo_data_in = 8'(8'h10 + i);
            if (i < 16) begin
                fr.data = 8'(8'h10 + i);
                sb.push_back(fr);
            end
            @(negedge clk);
        end
        tx_fifo_wr = 1'b0;
        check("ovf_count", 32'(tx_fifo_count), 32'd16);
        check("ovf_full", 32'(tx_fifo_full), 32'd1);
        check("ovf_flag", 32'(tx_overflow), 32'd1);
        check("ovf_no_tx", 32'(tx_busy), 32'd0);
        uart_control = mk_ctrl(1'b1, fr);
        busy_run(1'b1, len);
        check("burst_len", 32'(len), 32'd160);
        wait_idle(400);
        check("ovf_sticky", 32'(tx_overflow), 32'd1);
        check("burst_empty", 32'(tx_fifo_empty), 32'd1);

        // two stop bits, push then push+pop in the same cycle
        fr = '{8'h00, 10'd0, 1'b1, 1'b0, 1'b0};
        uart_control = mk_ctrl(1'b1, fr);
        sb.push_back(fr);
        push(8'h00);
        check("pp_count1", 32'(tx_fifo_count), 32'd1);
        fr.data = 8'hC3;
        sb.push_back(fr);
        push(8'hC3);
        check("pp_count2", 32'(tx_fifo_count), 32'd1);
        busy_run(1'b0, len);
        check("pp_len", 32'(len), 32'd22);
        wait_idle(200);

        // baud change mid-frame only affects the next frame
        fr = '{8'hA1, 10'd3, 1'b0, 1'b0, 1'b0};
        uart_control = mk_ctrl(1'b1, fr);
        sb.push_back(fr);
        push(8'hA1);
        fr = '{8'h7E, 10'd7, 1'b0, 1'b0, 1'b0};
        sb.push_back(fr);
        push(8'h7E);
        len = 0;
        while (tx_busy === 1'b1 && len < 5000) begin
            len++;
            if (len == 10) uart_control = mk_ctrl(1'b1, fr);
            @(negedge clk);
        end
        check("baud_chg_len", 32'(len), 32'd120);
        wait_idle(400);

        // reset during data bit 3 aborts the frame and flushes the FIFO
        mon_en = 1'b0;
        fr = '{8'hF0, 10'd3, 1'b0, 1'b0, 1'b0};
        uart_control = mk_ctrl(1'b1, fr);
        push(8'hF0);
        push(8'h33);
        repeat (16) @(negedge clk);
        check("pre_rst_txd", 32'(txd), 32'd0);
        check("pre_rst_busy", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_txd", 32'(txd), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_count", 32'(tx_fifo_count), 32'd0);
        check("mid_rst_ovf", 32'(tx_overflow), 32'd0);
        len = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_busy !== 1'b0) len++;
        end
        check("post_rst_quiet", 32'(len), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
